// File: rtl/scrambler_pkg.sv
// scrambler_pkg: shared loader states, BT.656 TRS constants and config-size helper (SCRAMBLER_CFG_CHECK_EN adds a checksum byte)
package scrambler_pkg;
  typedef enum logic [1:0] {LD_ISSUE, LD_WAIT, LD_CAPTURE, LD_DONE} ld_state_e;
  localparam logic [9:0] TRS_ONES = 10'h3FF;
  localparam logic [9:0] TRS_ZERO = 10'h000;
  localparam int XYZ_F = 8;
  localparam int XYZ_V = 7;
  localparam int XYZ_H = 6;
  localparam int MODE_BIT = 0;
`ifdef SCRAMBLER_CFG_CHECK_EN
  localparam bit CFG_CHECK = 1'b1;
`else
  localparam bit CFG_CHECK = 1'b0;
`endif
  function automatic int cfg_nbytes(input int seed_w, input int n_keys, input bit chk);
    return 1 + n_keys * (seed_w / 8) + (chk ? 1 : 0);
  endfunction
endpackage

// File: rtl/scrambler_cfg_loader.sv
// scrambler_cfg_loader: reads mode byte and seeds from the config ROM after reset (SCRAMBLER_CFG_CHECK_EN adds XOR checksum)
module scrambler_cfg_loader
  import scrambler_pkg::*;
#(
  parameter int SEED_W  = 256,
  parameter int N_KEYS  = 4,
  parameter int ROM_AW  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [ROM_AW-1:0]              rom_address,
  input  logic [7:0]                     rom_q,
  output logic                           cfg_done,
  output logic                           cfg_error,
  output logic                           mode,
  output logic [N_KEYS-1:0][SEED_W-1:0]  seeds_d
);
  localparam int BPS   = SEED_W / 8;
  localparam int NB    = cfg_nbytes(SEED_W, N_KEYS, CFG_CHECK);
  localparam int NDATA = 1 + N_KEYS * BPS;
  localparam int SW    = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  localparam int BW    = BPS > 1 ? $clog2(BPS) : 1;
  ld_state_e state, state_nxt;
  logic [1:0] wait_cnt;
  logic [SW-1:0] slot;
  logic [BW-1:0] byte_idx;
  logic [N_KEYS-1:0][SEED_W-1:0] seeds_q;
  logic last, is_seed, capture;
  assign last     = rom_address == ROM_AW'(NB - 1);
  assign is_seed  = rom_address != '0 && rom_address <= ROM_AW'(NDATA - 1);
  assign capture  = state == LD_CAPTURE;
  assign cfg_done = state == LD_DONE;
  // Loader state register; reset restarts the whole load
  always_ff @(posedge clk)
    if (!reset_n) state <= LD_ISSUE;
    else state <= state_nxt;
  // ISSUE counts as the first latency cycle, so each byte takes ROM_LAT+1 cycles
  always_comb begin
    state_nxt = state == LD_ISSUE   ? (ROM_LAT > 1 ? LD_WAIT : LD_CAPTURE) :
                state == LD_WAIT    ? (wait_cnt == 2'(ROM_LAT - 2) ? LD_CAPTURE : LD_WAIT) :
                state == LD_CAPTURE ? (last ? LD_DONE : LD_ISSUE) : LD_DONE;
  end
  // Seeds shift in MSB byte first; exported as next-state so the final byte is visible on the DONE edge
  always_comb begin
    seeds_d = seeds_q;
    if (capture && is_seed) seeds_d[slot] = (seeds_q[slot] << 8) | SEED_W'(rom_q);
  end
  // Address, byte/slot counters and mode capture
  always_ff @(posedge clk)
    if (!reset_n) begin
      rom_address <= '0;
      wait_cnt    <= '0;
      slot        <= '0;
      byte_idx    <= '0;
      mode        <= 1'b0;
      seeds_q     <= '0;
    end else begin
      wait_cnt <= state == LD_WAIT ? wait_cnt + 2'd1 : 2'd0;
      seeds_q  <= seeds_d;
      if (capture && !last) rom_address <= rom_address + ROM_AW'(1);
      if (capture && rom_address == '0) mode <= rom_q[MODE_BIT];
      if (capture && is_seed) begin
        byte_idx <= byte_idx == BW'(BPS - 1) ? '0 : byte_idx + BW'(1);
        if (byte_idx == BW'(BPS - 1)) slot <= slot + SW'(1);
      end
    end
`ifdef SCRAMBLER_CFG_CHECK_EN
  logic [7:0] csum;
  // Running XOR of config bytes; the trailing byte must match it
  always_ff @(posedge clk)
    if (!reset_n) begin
      csum      <= '0;
      cfg_error <= 1'b0;
    end else if (capture) begin
      if (last) cfg_error <= rom_q != csum;
      else csum <= csum ^ rom_q;
    end
`else
  assign cfg_error = 1'b0;
`endif
endmodule

// File: rtl/scrambler_core.sv
// scrambler_core: keystream XOR scrambler fed by the active seed, one register stage
module scrambler_core #(
  parameter int SEED_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEED_W-1:0] seed,
  input  logic [9:0]        din,
  output logic [9:0]        dout
);
  logic [9:0] ks;
  // Fold every seed bit into a 10-bit keystream word
  always_comb begin
    ks = '0;
    for (int i = 0; i < SEED_W; i++) ks[i % 10] = ks[i % 10] ^ seed[i];
  end
  // Scramble when mode is set, pass through otherwise; silent while held in reset
  always_ff @(posedge clk)
    if (!rst_n) dout <= '0;
    else dout <= din ^ (mode ? ks : 10'h000);
endmodule

// File: rtl/scrambler_mm_keyring.sv
// scrambler_mm_keyring: ROM-loaded seed keyring rotating at BT.656 field boundaries (SCRAMBLER_CFG_CHECK_EN enables checksum/bypass)
module scrambler_mm_keyring
  import scrambler_pkg::*;
#(
  parameter int SEED_W         = 256,
  parameter int N_KEYS         = 4,
  parameter int FIELDS_PER_KEY = 2,
  parameter int ROM_AW         = 8,
  parameter int ROM_LAT        = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        bt656_stream_in,
  output logic [9:0]        bt656_stream_out,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [3:0]        key_index
);
  localparam int SW = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  localparam int FW = $clog2(FIELDS_PER_KEY + 1);
  logic mode, core_rst_n, f_valid, last_f, eav, f, boundary, wrap;
  logic [N_KEYS-1:0][SEED_W-1:0] seeds_d;
  logic [SEED_W-1:0] seed_bus;
  logic [9:0] in_q, w2, w3, core_out;
  logic [FW-1:0] field_cnt;
  logic [3:0] key_nxt;
  scrambler_cfg_loader #(
    .SEED_W (SEED_W),
    .N_KEYS (N_KEYS),
    .ROM_AW (ROM_AW),
    .ROM_LAT(ROM_LAT)
  ) u_loader (
    .clk        (clk),
    .reset_n    (reset_n),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .cfg_done   (cfg_done),
    .cfg_error  (cfg_error),
    .mode       (mode),
    .seeds_d    (seeds_d)
  );
  // Input register plus two more words of history for the TRS preamble
  always_ff @(posedge clk) begin
    in_q <= bt656_stream_in;
    w2   <= in_q;
    w3   <= w2;
  end
  assign eav      = w3 == TRS_ONES && w2 == TRS_ZERO && in_q == TRS_ZERO && bt656_stream_in[XYZ_H];
  assign f        = bt656_stream_in[XYZ_F];
  assign boundary = cfg_done && eav && f_valid && f != last_f;
  assign wrap     = boundary && field_cnt == FW'(FIELDS_PER_KEY - 1);
  assign key_nxt  = wrap ? (key_index == 4'(N_KEYS - 1) ? 4'd0 : key_index + 4'd1) : key_index;
  // Field tracking, key rotation and the registered seed bus (moves only on the advancing XYZ)
  always_ff @(posedge clk)
    if (!reset_n) begin
      f_valid   <= 1'b0;
      last_f    <= 1'b0;
      field_cnt <= '0;
      key_index <= '0;
      seed_bus  <= '0;
    end else begin
      if (cfg_done && eav) begin
        f_valid <= 1'b1;
        last_f  <= f;
      end
      if (boundary) field_cnt <= wrap ? '0 : field_cnt + FW'(1);
      key_index <= key_nxt;
      seed_bus  <= seeds_d[SW'(key_nxt)];
    end
  assign core_rst_n = reset_n && cfg_done && !cfg_error;
  scrambler_core #(.SEED_W(SEED_W)) u_core (
    .clk  (clk),
    .rst_n(core_rst_n),
    .mode (mode),
    .seed (seed_bus),
    .din  (in_q),
    .dout (core_out)
  );
  assign bt656_stream_out = cfg_error ? in_q : core_out;
endmodule
